// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// clock-driven bit shift, ACK sample and bus-idle wait.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       ps2c_low,
  output logic       ps2d_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] INH_MAX  = IW'(INHIBIT_CYCLES);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [7:0]    data;
  logic          parity;
  logic [3:0]    n;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;

  logic c_s1, c_s2, c_prev;
  logic d_s1, d_s2;
  logic fe;

  assign fe = c_prev & ~c_s2;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state    <= IDLE;
      data     <= '0;
      parity   <= 1'b0;
      n        <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      c_s1     <= 1'b1;
      c_s2     <= 1'b1;
      c_prev   <= 1'b1;
      d_s1     <= 1'b1;
      d_s2     <= 1'b1;
      ps2c_low <= 1'b0;
      ps2d_low <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      c_s1    <= PS2C;
      c_s2    <= c_s1;
      c_prev  <= c_s2;
      d_s1    <= PS2D;
      d_s2    <= d_s1;
      done    <= 1'b0;
      timeout <= 1'b0;

      unique case (state)
        IDLE: begin
          if (tx_start) begin
            data     <= tx_data;
            parity   <= ~^tx_data;
            ack_err  <= 1'b0;
            busy     <= 1'b1;
            ps2c_low <= 1'b1;
            ps2d_low <= 1'b0;
            inh_cnt  <= '0;
            state    <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_cnt != INH_MAX)
            inh_cnt <= inh_cnt + IW'(1);
          if (inh_cnt == INH_PRE)
            ps2d_low <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            ps2c_low <= 1'b0;
            ps2d_low <= 1'b1;
            n        <= '0;
            to_cnt   <= '0;
            state    <= REQ;
          end
        end

        REQ, SHIFT: begin
          if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + TW'(1);
          if (to_cnt == TO_LAST) begin
            ps2c_low <= 1'b0;
            ps2d_low <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            state    <= IDLE;
          end else if (fe) begin
            // n is the edge count before this edge; bit index = n
            state <= SHIFT;
            n     <= n + 4'd1;
            case (n)
              4'd8:  ps2d_low <= ~parity;
              4'd9:  ps2d_low <= 1'b0;
              4'd10: begin
                ack_err <= d_s2;
                state   <= WAIT_IDLE;
              end
              default: ps2d_low <= ~data[n[2:0]];
            endcase
          end
        end

        WAIT_IDLE: begin
          if (c_s2 && d_s2) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the open-drain pair,
// frame/ack scoreboard, plus a second instance for timeout.
module tb_ps2_host_tx;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic [7:0] to_data = '0;
  logic       to_start = 1'b0;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       nack_mode = 1'b0;

  logic c_low, d_low, busy, done, ack_err, tout;
  logic to_c_low, to_d_low, to_busy, to_done, to_ack, to_tout;

  wire c_pin    = ~c_low & dev_c;
  wire d_pin    = ~d_low & dev_d;
  wire to_c_pin = ~to_c_low;
  wire to_d_pin = ~to_d_low;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int to_tout_cnt = 0;
  int to_done_cnt = 0;

  logic [10:0] exp_frame_q[$];
  logic [10:0] got_q[$];
  logic        exp_ack_q[$];

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(8),
    .TIMEOUT_CYCLES(2000)
  ) u_dut (
    .MCLK(clk), .reset(reset),
    .tx_data(tx_data), .tx_start(tx_start),
    .PS2C(c_pin), .PS2D(d_pin),
    .ps2c_low(c_low), .ps2d_low(d_low),
    .busy(busy), .done(done),
    .ack_err(ack_err), .timeout(tout)
  );

  ps2_host_tx #(
    .INHIBIT_CYCLES(8),
    .TIMEOUT_CYCLES(200)
  ) u_to (
    .MCLK(clk), .reset(reset),
    .tx_data(to_data), .tx_start(to_start),
    .PS2C(to_c_pin), .PS2D(to_d_pin),
    .ps2c_low(to_c_low), .ps2d_low(to_d_low),
    .busy(to_busy), .done(to_done),
    .ack_err(to_ack), .timeout(to_tout)
  );

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Device: waits for request-to-send, clocks 11 edges, samples on rise
  initial begin
    logic [10:0] fr;
    forever begin
      @(negedge clk);
      if (c_pin && !d_pin) begin
        repeat (H) @(negedge clk);
        fr[0] = d_pin;
        for (int i = 1; i <= 11; i++) begin
          dev_c = 1'b0;
          repeat (H) @(negedge clk);
          dev_c = 1'b1;
          if (i <= 10) fr[i] = d_pin;
          if (i == 10 && !nack_mode) dev_d = 1'b0;
          if (i == 11) dev_d = 1'b1;
          repeat (H) @(negedge clk);
        end
        got_q.push_back(fr);
      end
    end
  end

  // Frame monitor
  initial begin
    logic [10:0] g;
    forever begin
      @(negedge clk);
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        if (exp_frame_q.size() == 0) chk("frame_extra", 1, 0);
        else chk("frame", g, exp_frame_q.pop_front());
      end
    end
  end

  // Done monitor
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
        if (exp_ack_q.size() == 0) chk("done_extra", 1, 0);
        else chk("ack_err", ack_err, exp_ack_q.pop_front());
      end
    end
  end

  // Inhibit length and start-bit lead on the main instance
  initial begin
    int inh_len = 0;
    int d_first = 0;
    logic cp = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        inh_len = 0;
        d_first = 0;
        cp = 1'b0;
      end else begin
        if (c_low) begin
          inh_len++;
          if (d_low && d_first == 0) d_first = inh_len;
        end else if (cp) begin
          chk("inhibit_len", inh_len, 8);
          chk("start_lead", d_first, 8);
          chk("req_dlow", d_low, 1);
          inh_len = 0;
          d_first = 0;
        end
        cp = c_low;
      end
    end
  end

  // Timeout instance monitor
  initial begin
    int cyc = 0;
    int t0 = 0;
    logic tp = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && tp && !to_c_low) t0 = cyc;
      if (to_tout) begin
        to_tout_cnt++;
        chk("to_delay", cyc - t0, 200);
        chk("to_c_rel", to_c_low, 0);
        chk("to_d_rel", to_d_low, 0);
        chk("to_busy", to_busy, 0);
      end
      if (to_done) to_done_cnt++;
      tp = to_c_low;
    end
  end

  task automatic send(input logic [7:0] b, input logic par,
                      input logic nk, input logic dup);
    exp_frame_q.push_back({1'b1, par, b, 1'b0});
    exp_ack_q.push_back(nk);
    nack_mode = nk;
    tx_data = b;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("c_low_rise", c_low, 1);
    chk("ack_clr", ack_err, 0);
    if (dup) begin
      repeat (100) tick;
      tx_data = 8'h55;
      tx_start = 1'b1;
      tick;
      tx_start = 1'b0;
      chk("dup_busy", busy, 1);
    end
    for (int i = 0; i < 3000 && busy; i++) tick;
    chk("busy_end", busy, 0);
    repeat (40) tick;
  endtask

  logic [7:0] vb[6];
  logic       vp[6];
  logic       vn[6];
  logic       vd[6];

  initial begin
    vb[0] = 8'hED; vp[0] = 1'b1; vn[0] = 1'b0; vd[0] = 1'b0;
    vb[1] = 8'h01; vp[1] = 1'b0; vn[1] = 1'b0; vd[1] = 1'b0;
    vb[2] = 8'h00; vp[2] = 1'b1; vn[2] = 1'b0; vd[2] = 1'b0;
    vb[3] = 8'hFF; vp[3] = 1'b1; vn[3] = 1'b0; vd[3] = 1'b1;
    vb[4] = 8'hA5; vp[4] = 1'b1; vn[4] = 1'b1; vd[4] = 1'b0;
    vb[5] = 8'h5A; vp[5] = 1'b1; vn[5] = 1'b0; vd[5] = 1'b0;

    repeat (3) tick;
    reset = 1'b0;
    tick;
    chk("rst_c_low", c_low, 0);
    chk("rst_d_low", d_low, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", ack_err, 0);
    chk("rst_tout", tout, 0);

    // reset in the middle of INHIBIT
    tx_data = 8'hED;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    chk("mid_rst_c", c_low, 0);
    chk("mid_rst_d", d_low, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) tick;
    reset = 1'b0;
    tick;
    chk("post_rst_c", c_low, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    repeat (5) tick;

    for (int k = 0; k < 6; k++) begin
      if (k == 5) chk("ack_hold", ack_err, 1);
      send(vb[k], vp[k], vn[k], vd[k]);
    end

    to_data = 8'h3C;
    to_start = 1'b1;
    tick;
    to_start = 1'b0;
    chk("to_busy_rise", to_busy, 1);
    for (int i = 0; i < 1000 && to_tout_cnt == 0; i++) tick;
    chk("to_pulses", to_tout_cnt, 1);
    repeat (20) tick;

    repeat (100) tick;
    chk("done_count", done_cnt, 6);
    chk("to_done_count", to_done_cnt, 0);
    chk("frame_q_empty", exp_frame_q.size(), 0);
    chk("ack_q_empty", exp_ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
